// File: rtl/seq_divider16_if.sv
// Handshake and operand/result bundle for the iterative 16-bit divider.
interface seq_divider16_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// Restoring unsigned 16-bit divider, one quotient bit per clock, with a
// 16-bit carry-lookahead adder used as the trial subtractor.
module cla16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] sum
);
  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [4:0]  cg_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Per-nibble group generate and propagate.
  always_comb begin
    gg_s = 4'b0000;
    gp_s = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      gg_s[j] = g_s[4*j+3] | (p_s[4*j+3] & g_s[4*j+2])
              | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
              | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j]);
      gp_s[j] = &p_s[4*j +: 4];
    end
  end

  // Group carries, fully expanded from cin so no group waits on another.
  always_comb begin
    cg_s    = 5'b00000;
    cg_s[0] = cin;
    cg_s[1] = gg_s[0] | (gp_s[0] & cin);
    cg_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
    cg_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
    cg_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
            | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
  end

  // Bit carries inside each nibble from that nibble's group carry-in.
  always_comb begin
    c_s = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      c_s[4*j]   = cg_s[j];
      c_s[4*j+1] = g_s[4*j] | (p_s[4*j] & cg_s[j]);
      c_s[4*j+2] = g_s[4*j+1] | (p_s[4*j+1] & g_s[4*j])
                 | (p_s[4*j+1] & p_s[4*j] & cg_s[j]);
      c_s[4*j+3] = g_s[4*j+2] | (p_s[4*j+2] & g_s[4*j+1])
                 | (p_s[4*j+2] & p_s[4*j+1] & g_s[4*j])
                 | (p_s[4*j+2] & p_s[4*j+1] & p_s[4*j] & cg_s[j]);
    end
  end

  assign sum = {cg_s[4], p_s ^ c_s};
endmodule

module seq_divider16 #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] DIV0_QUOT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  seq_divider16_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH:0]   trial_s;

  // Partial remainder picks up the next dividend bit; it never needs a 17th bit.
  assign shifted_s = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

  cla16x16 u_sub (
    .a   (shifted_s),
    .b   (~dsr_q),
    .cin (1'b1),
    .sum (trial_s)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dsr_d   = bus.divisor;
          rem_d   = 16'h0000;
          quot_d  = 16'h0000;
          count_d = 4'd0;
          dz_d    = 1'b0;
          if (bus.divisor == 16'h0000) begin
            quot_d  = DIV0_QUOT;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Carry out of shifted + ~divisor + 1 means shifted >= divisor.
        if (trial_s[WIDTH]) begin
          rem_d = trial_s[WIDTH-1:0];
        end else begin
          rem_d = shifted_s;
        end
        quot_d  = {quot_q[WIDTH-2:0], trial_s[WIDTH]};
        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
        count_d = count_q + 4'd1;
        if (count_q == 4'd15) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      dvd_q   <= 16'h0000;
      dsr_q   <= 16'h0000;
      rem_q   <= 16'h0000;
      quot_q  <= 16'h0000;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider16.sv
// Directed-vector and random bench for seq_divider16; drives and samples on the falling edge.
module tb_seq_divider16;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  seq_divider16_if bus ();

  seq_divider16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dsr;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation; returns results sampled when done is seen and the edge count to it.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic dz, output int lat);
    @(negedge clk);
    chk("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start    = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 16'($urandom);
    end while (!bus.done && lat < 40);
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
  endtask

  initial begin
    logic [15:0] q, r, a, b;
    logic        dz;
    int          lat;
    int          dones;

    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{16'd100,   16'd7,     16'd14,    16'd2,   1'b0};
    vecs[1]  = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,   1'b0};
    vecs[2]  = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,   1'b0};
    vecs[3]  = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1};
    vecs[4]  = '{16'd5,     16'd9,     16'd0,     16'd5,   1'b0};
    vecs[5]  = '{16'd0,     16'd3,     16'd0,     16'd0,   1'b0};
    vecs[6]  = '{16'd1000,  16'd10,    16'd100,   16'd0,   1'b0};
    vecs[7]  = '{16'd0,     16'd0,     16'hFFFF,  16'd0,   1'b1};
    vecs[8]  = '{16'd1,     16'd1,     16'd1,     16'd0,   1'b0};
    vecs[9]  = '{16'd65535, 16'd256,   16'd255,   16'd255, 1'b0};
    vecs[10] = '{16'd40000, 16'd3,     16'd13333, 16'd1,   1'b0};
    vecs[11] = '{16'd12345, 16'd12346, 16'd0,     16'd12345, 1'b0};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'h0000;
    bus.divisor  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quot", 32'(bus.quotient), 32'd0);
    chk("rst_rem", 32'(bus.remainder), 32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    // Table vectors issued back to back.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dvd, vecs[i].dsr, q, r, dz, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), (vecs[i].dsr == 16'd0) ? 32'd1 : 32'd17);
      chk($sformatf("vec%0d_quot", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_rem", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
    end

    // Results hold in IDLE; done was a single pulse.
    repeat (3) @(negedge clk);
    chk("hold_done", 32'(bus.done), 32'd0);
    chk("hold_ready", 32'(bus.ready), 32'd1);
    chk("hold_quot", 32'(bus.quotient), 32'd0);
    chk("hold_rem", 32'(bus.remainder), 32'd12345);

    // start held high all through RUN must not launch a second op.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd10;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.dividend = 16'd7; bus.divisor = 16'd2;
      if (bus.done) begin
        dones++;
        bus.start = 1'b0;
        chk("busy_quot", 32'(bus.quotient), 32'd100);
        chk("busy_rem", 32'(bus.remainder), 32'd0);
      end
    end
    bus.start = 1'b0;
    chk("busy_done_count", 32'(dones), 32'd1);

    // Reset at RUN count 7 aborts with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 16'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_quot", 32'(bus.quotient), 32'd0);
    chk("mid_rst_rem", 32'(bus.remainder), 32'd0);
    chk("mid_rst_dz", 32'(bus.div_by_zero), 32'd0);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);

    // Random operands against the language's / and %.
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      run_op(a, b, q, r, dz, lat);
      if (b == 16'd0) begin
        chk("rnd_quot", 32'(q), 32'hFFFF);
        chk("rnd_rem", 32'(r), 32'(a));
        chk("rnd_dz", 32'(dz), 32'd1);
      end else begin
        chk("rnd_quot", 32'(q), 32'(a / b));
        chk("rnd_rem", 32'(r), 32'(a % b));
        chk("rnd_dz", 32'(dz), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
